// File: rtl/seq_pkg.sv
// Shared types, opcode map and decode helpers for the multi-cycle sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALTED
  } seq_state_t;

  localparam logic [5:0] OP_SUMA  = 6'd1;
  localparam logic [5:0] OP_RESTA = 6'd2;
  localparam logic [5:0] OP_MOV   = 6'd3;
  localparam logic [5:0] OP_DIV   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_AND   = 6'd6;
  localparam logic [5:0] OP_OR    = 6'd7;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  function automatic logic is_multicycle(input logic [5:0] op);
    return (op == OP_DIV) || (op == OP_MUL);
  endfunction

  // HALT counts as legal; it is filtered separately in DECODE.
  function automatic logic is_legal(input logic [5:0] op);
    return ((op >= OP_SUMA) && (op <= OP_OR)) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/seq_if.sv
// Instruction-memory and ALU handshake bundle between the sequencer and its neighbours.
interface seq_if #(parameter int PC_W = 8);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_data;
  logic            alu_start;
  logic            alu_done;

  modport master (output imem_req, imem_addr, alu_start,
                  input  imem_ready, imem_data, alu_done);
  modport slave  (input  imem_req, imem_addr, alu_start,
                  output imem_ready, imem_data, alu_done);
endinterface

// File: rtl/seq_watchdog.sv
// Counts consecutive WAIT cycles and flags the cycle in which the limit is reached.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_wait,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  assign cnt_d  = in_wait ? cnt_q + 1'b1 : '0;
  assign expire = in_wait && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// Fetch/decode/execute/writeback sequencer with ALU wait and gated writeback strobes.
// Optional ALU watchdog enabled by defining SEQ_WATCHDOG_EN.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] PC_RESET = '0
`ifdef SEQ_WATCHDOG_EN
  , parameter int            TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  seq_if.master       bus,
  output logic [31:0] ir,
  input  logic        cu_rwe,
  input  logic        cu_rwe2,
  input  logic        cu_mwe,
  output logic        rf_we,
  output logic        rf_we2,
  output logic        mem_we,
  output logic        busy,
  output logic        halted,
  output logic        illegal_op,
  output logic [15:0] retired_cnt
`ifdef SEQ_WATCHDOG_EN
  , output logic      timeout_err
`endif
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [2:0]      wb_q;
  logic            ill_q;
  logic [15:0]     ret_q;
  logic [5:0]      op;
  logic            wd_expire;

  assign op = ir_q[31:26];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (bus.imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_HALT)   state_d = S_HALTED;
        else if (is_legal(op)) state_d = S_EXEC;
        else                 state_d = S_FETCH;
      end
      S_EXEC:   state_d = is_multicycle(op) ? S_WAIT : S_WB;
      S_WAIT: begin
        if (bus.alu_done)   state_d = S_WB;
        else if (wd_expire) state_d = S_HALTED;
      end
      S_WB:     state_d = S_FETCH;
      S_HALTED: if (start) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      wb_q    <= '0;
      ill_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      // Strobes are captured on WB entry so they come straight from a flop;
      // the cu_* enables are already stable since they only depend on ir.
      wb_q    <= (state_d == S_WB) ? {cu_mwe, cu_rwe2, cu_rwe} : 3'b000;
      if (state_q == S_FETCH && bus.imem_ready) begin
        ir_q <= bus.imem_data;
        pc_q <= pc_q + 1'b1;
      end
      if (state_q == S_HALTED && start) pc_q <= PC_RESET;
      if (state_q == S_DECODE && !is_legal(op)) ill_q <= 1'b1;
      if (state_q == S_WB && ret_q != 16'hFFFF) ret_q <= ret_q + 16'd1;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  logic to_q;

  seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_wait (state_q == S_WAIT),
    .expire  (wd_expire)
  );

  // A done arriving on the limit cycle wins, so only a true miss is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= 1'b0;
    else if (state_q == S_WAIT && !bus.alu_done && wd_expire) to_q <= 1'b1;
  end

  assign timeout_err = to_q;
`else
  assign wd_expire = 1'b0;
`endif

  assign bus.imem_req  = (state_q == S_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.alu_start = (state_q == S_EXEC) && is_multicycle(op);
  assign ir            = ir_q;
  assign {mem_we, rf_we2, rf_we} = wb_q;
  assign busy          = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted        = (state_q == S_HALTED);
  assign illegal_op    = ill_q;
  assign retired_cnt   = ret_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

- Multi-cycle instruction sequencer that drives the processor's fetch/decode/execute/writeback loop.
- Fetches 32-bit instructions over a ready/valid-style instruction-memory port and holds the current instruction in an instruction register (`ir`) feeding the combinational control unit.
- Starts and waits on the ALU for variable-latency DIV/MUL.
- Gates the control unit's raw write enables (`cu_rwe`, `cu_rwe2`, `cu_mwe`) into single-cycle writeback strobes.
- Sits between instruction memory, the control unit, the ALU and the register file/data memory.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction address width.
- `PC_RESET`, 0, PC value after reset and after restart from HALTED.
- `TIMEOUT_CYCLES`, 64, ALU watchdog limit. Used only with `SEQ_WATCHDOG_EN`.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level, sampled in IDLE/HALTED; begins execution.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out `PC_W`: fetch address; equals `pc`.
- `imem_ready` in 1: fetch data valid this cycle.
- `imem_data` in 32: fetched instruction.
- `ir` out 32: latched instruction, fed to the control unit.
- `cu_rwe`, `cu_rwe2`, `cu_mwe` in 1 each: raw enables from the control unit.
- `alu_start` out 1: one-cycle pulse starting a DIV/MUL.
- `alu_done` in 1: DIV/MUL result ready.
- `rf_we`, `rf_we2`, `mem_we` out 1 each: gated writeback strobes.
- `busy` out 1: high in every state except IDLE and HALTED.
- `halted` out 1: high in HALTED.
- `illegal_op` out 1: sticky flag, set by an illegal opcode.
- `retired_cnt` out 16: count of retired legal instructions; saturates at 16'hFFFF.
- `timeout_err` out 1: sticky flag. Exists only with `SEQ_WATCHDOG_EN`.

## Operation
- **Opcode field:** `ir[31:26]`.
- **Single-cycle opcodes:** 1 SUMA, 2 RESTA, 3 MOV, 6 AND, 7 OR.
- **Multi-cycle opcodes:** 4 DIV, 5 MUL.
- **HALT:** 6'h3F.
- **Illegal opcodes:** 0 and 8..62.
- **IDLE**
  - If `start`: go to FETCH.
- **FETCH**
  - `imem_req`=1, `imem_addr`=`pc`; `imem_req` stays high until `imem_ready`.
  - On `imem_ready`: `ir`<=`imem_data`, `pc`<=`pc`+1 (wraps mod 2^`PC_W`), go to DECODE.
- **DECODE** (one cycle; control unit settles on `ir`)
  - HALT: go to HALTED. Not counted.
  - Illegal: set `illegal_op`, go to FETCH. No strobes, not counted.
  - Otherwise: go to EXEC.
- **EXEC**
  - Single-cycle op: go to WB.
  - DIV/MUL: pulse `alu_start` for exactly one cycle, go to WAIT.
- **WAIT**
  - Hold until `alu_done`, then go to WB.
  - `alu_done` is sampled only in WAIT; it is ignored in every other state.
- **WB** (one cycle)
  - `rf_we`=`cu_rwe`, `rf_we2`=`cu_rwe2`, `mem_we`=`cu_mwe`.
  - Increment `retired_cnt` (saturating).
  - Go to FETCH.
- **HALTED**
  - `halted`=1.
  - `start`: `pc`<=`PC_RESET`, go to FETCH.
  - `retired_cnt` and `illegal_op` are kept.
- **Strobes outside WB:** `rf_we`, `rf_we2` and `mem_we` are 0 in every state other than WB, whatever the `cu_*` inputs are.
- **Reset values** (`rst_n` low, any state, including mid-fetch or mid-WAIT; takes effect immediately, asynchronous):
  - state=IDLE, `pc`=`PC_RESET`, `ir`=0.
  - All strobes and `alu_start` 0; `busy` 0; `halted` 0.
  - `illegal_op` 0, `retired_cnt` 0, `timeout_err` 0.
  - An in-flight ALU operation is abandoned.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- Single-cycle op with `imem_ready` on the first FETCH cycle: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
- DIV/MUL: 4 cycles + N, where N = cycles spent in WAIT (≥1).
- Each cycle of `imem_ready` low in FETCH adds one cycle.
- `alu_start` is asserted in the EXEC cycle; the earliest accepted `alu_done` is the following cycle.
- `start` held high in IDLE: FETCH is entered on the next edge.

## Configuration
- **Macro:** `SEQ_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on WAIT entry and increments each cycle spent in WAIT.
  - When it reaches `TIMEOUT_CYCLES` without `alu_done`: set sticky `timeout_err`, go to HALTED, no writeback, instruction not counted.
  - `alu_done` arriving in the same cycle the limit is reached wins: normal WB.
- **Undefined:**
  - No counter and no `timeout_err` port.
  - WAIT holds indefinitely.

## Structure
- Package `seq_pkg` holds:
  - the `seq_state_t` enum (IDLE, FETCH, DECODE, EXEC, WAIT, WB, HALTED);
  - opcode localparams `OP_SUMA`..`OP_OR` and `OP_HALT`;
  - functions `is_multicycle(op)` and `is_legal(op)`.
- The watchdog is the one natural sub-module, `seq_watchdog`. It is instantiated only under `SEQ_WATCHDOG_EN`.

## Test plan
- **Reset then run single ops:** release `rst_n`, `start`=1, `imem_ready` always 1, program SUMA, OR, HALT.
  - Expect: `rf_we` pulses on cycles 4 and 8, `halted`=1, `retired_cnt`=2, `pc`=3.
- **DIV with delayed `alu_done`:** `alu_done` arrives 5 cycles after `alu_start`.
  - Expect: exactly one `alu_start` pulse, WB one cycle after `alu_done`, latency 9 cycles.
- **Illegal opcode 6'h08 followed by MOV.**
  - Expect: `illegal_op`=1 and stays set; no strobes for opcode 6'h08; `rf_we2` pulses in the MOV's WB; `retired_cnt`=1.
- **Fetch stall and PC wrap:** `imem_ready` low for 3 cycles; start with `pc`=8'hFF.
  - Expect: `imem_req` held for 4 cycles; `pc` wraps to 0.
- **Async reset in WAIT:** assert `rst_n` low mid-DIV.
  - Expect: immediate IDLE, all outputs at reset values; no WB after release.
- **Watchdog (with `SEQ_WATCHDOG_EN`):** `TIMEOUT_CYCLES`=4, `alu_done` never asserted.
  - Expect: `timeout_err`=1 and `halted`=1 after 4 WAIT cycles; `retired_cnt` unchanged.
